// File: rtl/seq_pkg.sv
// Shared widths, opcodes, state encoding and control payload for the instruction sequencer.
package seq_pkg;

    localparam int unsigned PC_W    = 3;
    localparam int unsigned DATA_W  = 4;
    localparam int unsigned OPC_W   = 4;
    localparam int unsigned INSTR_W = 8;

    // Instruction layout: {opcode, operand}
    localparam int unsigned OPC_MSB = 7;
    localparam int unsigned OPC_LSB = 4;

    localparam logic [OPC_W-1:0] OP_NOP = 4'h0;
    localparam logic [OPC_W-1:0] OP_ADD = 4'h1;
    localparam logic [OPC_W-1:0] OP_SUB = 4'h2;
    localparam logic [OPC_W-1:0] OP_OUT = 4'h3;
    localparam logic [OPC_W-1:0] OP_IN  = 4'h4;
    localparam logic [OPC_W-1:0] OP_LDB = 4'h5;
    localparam logic [OPC_W-1:0] OP_LDA = 4'h6;
    localparam logic [OPC_W-1:0] OP_JMP = 4'h7;
    localparam logic [OPC_W-1:0] OP_JZ  = 4'h8;
    localparam logic [OPC_W-1:0] OP_HLT = 4'hF;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_FETCH   = 3'd1,
        ST_LATCH   = 3'd2,
        ST_EXEC    = 3'd3,
        ST_WAIT_IN = 3'd4,
        ST_HALT    = 3'd5
    } state_e;

    typedef enum logic [1:0] {
        PC_HOLD = 2'd0,
        PC_INC  = 2'd1,
        PC_JUMP = 2'd2
    } pc_sel_e;

    // Bus-driver enables and register strobes toward the datapath.
    typedef struct packed {
        logic bus_in_en;
        logic bus_alu_en;
        logic bus_acc_en;
        logic bus_imm_en;
        logic a_load;
        logic b_load;
        logic out_load;
        logic alu_sub;
    } ctrl_t;

    function automatic logic [OPC_W-1:0] opcode_of(input logic [INSTR_W-1:0] instr);
        return instr[OPC_MSB:OPC_LSB];
    endfunction

endpackage

// File: rtl/instr_sequencer_if.sv
// Sequencer <-> memory/datapath/front-panel signal bundle.
interface instr_sequencer_if;
    import seq_pkg::*;

    logic                run;
    logic                step;
    logic [PC_W-1:0]     mem_addr;
    logic                mem_rd;
    logic [INSTR_W-1:0]  mem_rdata;
    logic                in_valid;
    logic                in_ready;
    logic                bus_in_en;
    logic                bus_alu_en;
    logic                bus_acc_en;
    logic                bus_imm_en;
    logic [DATA_W-1:0]   imm;
    logic                a_load;
    logic                b_load;
    logic                out_load;
    logic                alu_sub;
    logic                acc_zero;
    logic                halted;
    logic [PC_W-1:0]     pc;

    // Sequencer side
    modport master (
        input  run, step, mem_rdata, in_valid, acc_zero,
        output mem_addr, mem_rd, in_ready, bus_in_en, bus_alu_en, bus_acc_en,
               bus_imm_en, imm, a_load, b_load, out_load, alu_sub, halted, pc
    );

    // Memory / datapath / panel side
    modport slave (
        output run, step, mem_rdata, in_valid, acc_zero,
        input  mem_addr, mem_rd, in_ready, bus_in_en, bus_alu_en, bus_acc_en,
               bus_imm_en, imm, a_load, b_load, out_load, alu_sub, halted, pc
    );

endinterface

// File: rtl/instr_decode.sv
// Combinational decode of state + opcode into datapath controls and pc update select.
module instr_decode
    import seq_pkg::*;
(
    input  state_e           state,
    input  logic [OPC_W-1:0] opcode,
    input  logic             acc_zero,
    input  logic             in_valid,
    output ctrl_t            ctrl_c,
    output logic             mem_rd_c,
    output logic             in_ready_c,
    output logic             halted_c,
    output pc_sel_e          pc_sel_c
);

    // Strobes are pure functions of the current state, so each lasts exactly one cycle.
    always_comb begin
        ctrl_c     = '0;
        mem_rd_c   = 1'b0;
        in_ready_c = 1'b0;
        halted_c   = 1'b0;
        pc_sel_c   = PC_HOLD;
        case (state)
            ST_FETCH: mem_rd_c = 1'b1;
            ST_LATCH: pc_sel_c = PC_INC;
            ST_EXEC: begin
                case (opcode)
                    OP_NOP: ;
                    OP_ADD: begin
                        ctrl_c.bus_alu_en = 1'b1;
                        ctrl_c.a_load     = 1'b1;
                    end
                    OP_SUB: begin
                        ctrl_c.bus_alu_en = 1'b1;
                        ctrl_c.a_load     = 1'b1;
                        ctrl_c.alu_sub    = 1'b1;
                    end
                    OP_OUT: begin
                        ctrl_c.bus_acc_en = 1'b1;
                        ctrl_c.out_load   = 1'b1;
                    end
                    OP_LDB: begin
                        ctrl_c.bus_imm_en = 1'b1;
                        ctrl_c.b_load     = 1'b1;
                    end
                    OP_LDA: begin
                        ctrl_c.bus_imm_en = 1'b1;
                        ctrl_c.a_load     = 1'b1;
                    end
                    OP_JMP: pc_sel_c = PC_JUMP;
                    OP_JZ:  pc_sel_c = acc_zero ? PC_JUMP : PC_HOLD;
                    // HLT is reported as executed already in its EXEC cycle
                    OP_HLT: halted_c = 1'b1;
                    default: ;
                endcase
            end
            ST_WAIT_IN: begin
                in_ready_c = 1'b1;
                if (in_valid) begin
                    ctrl_c.bus_in_en = 1'b1;
                    ctrl_c.a_load    = 1'b1;
                end
            end
            ST_HALT: halted_c = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: rtl/instr_sequencer.sv
// Control FSM for the 4-bit accumulator CPU: fetch/latch/exec, run/step/halt and IN handshake.
module instr_sequencer
    import seq_pkg::*;
(
    input  logic                  MainClock,
    input  logic                  MainClear,
    instr_sequencer_if.master     sif
);

    state_e               state_q;
    state_e               state_d;
    logic [PC_W-1:0]      pc_q;
    logic [PC_W-1:0]      pc_d;
    logic [INSTR_W-1:0]   ir_q;
    logic [OPC_W-1:0]     opcode;
    ctrl_t                ctrl;
    logic                 mem_rd;
    logic                 in_ready;
    logic                 halted;
    pc_sel_e              pc_sel;

    assign opcode = opcode_of(ir_q);

    instr_decode u_decode (
        .state      (state_q),
        .opcode     (opcode),
        .acc_zero   (sif.acc_zero),
        .in_valid   (sif.in_valid),
        .ctrl_c     (ctrl),
        .mem_rd_c   (mem_rd),
        .in_ready_c (in_ready),
        .halted_c   (halted),
        .pc_sel_c   (pc_sel)
    );

    // State register; clear wins over everything, including WAIT_IN and HALT.
    always_ff @(posedge MainClock) begin
        if (MainClear) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: after an instruction, continue only while run is held.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:    if (sif.run || sif.step) state_d = ST_FETCH;
            ST_FETCH:   state_d = ST_LATCH;
            ST_LATCH:   state_d = ST_EXEC;
            ST_EXEC: begin
                if (opcode == OP_IN) begin
                    state_d = ST_WAIT_IN;
                end else if (opcode == OP_HLT) begin
                    state_d = ST_HALT;
                end else begin
                    state_d = sif.run ? ST_FETCH : ST_IDLE;
                end
            end
            ST_WAIT_IN: if (sif.in_valid) state_d = sif.run ? ST_FETCH : ST_IDLE;
            ST_HALT:    state_d = ST_HALT;
            default:    state_d = ST_IDLE;
        endcase
    end

    // Program counter update: increment in LATCH wraps modulo 8; jumps take the operand low bits.
    always_comb begin
        pc_d = pc_q;
        case (pc_sel)
            PC_INC:  pc_d = PC_W'(pc_q + PC_W'(1));
            PC_JUMP: pc_d = ir_q[PC_W-1:0];
            default: pc_d = pc_q;
        endcase
    end

    // pc and instruction register.
    always_ff @(posedge MainClock) begin
        if (MainClear) begin
            pc_q <= '0;
            ir_q <= '0;
        end else begin
            pc_q <= pc_d;
            if (state_q == ST_LATCH) begin
                ir_q <= sif.mem_rdata;
            end
        end
    end

    assign sif.mem_addr   = pc_q;
    assign sif.mem_rd     = mem_rd;
    assign sif.in_ready   = in_ready;
    assign sif.bus_in_en  = ctrl.bus_in_en;
    assign sif.bus_alu_en = ctrl.bus_alu_en;
    assign sif.bus_acc_en = ctrl.bus_acc_en;
    assign sif.bus_imm_en = ctrl.bus_imm_en;
    assign sif.imm        = ir_q[DATA_W-1:0];
    assign sif.a_load     = ctrl.a_load;
    assign sif.b_load     = ctrl.b_load;
    assign sif.out_load   = ctrl.out_load;
    assign sif.alu_sub    = ctrl.alu_sub;
    assign sif.halted     = halted;
    assign sif.pc         = pc_q;

endmodule

// File: tb/tb_instr_sequencer.sv
// Directed table-driven bench for instr_sequencer with a registered program memory model.
module tb_instr_sequencer;

    logic MainClock;
    logic MainClear;

    instr_sequencer_if sif();

    instr_sequencer dut (
        .MainClock (MainClock),
        .MainClear (MainClear),
        .sif       (sif)
    );

    initial begin
        MainClock = 1'b0;
        forever #5 MainClock = ~MainClock;
    end

    // Program memory: data appears on mem_rdata the cycle after mem_rd.
    logic [7:0] mem [8];
    always @(posedge MainClock) begin
        if (sif.mem_rd) sif.mem_rdata <= mem[sif.mem_addr];
    end

    // Signature bits: {mem_rd,in_ready,bus_in,bus_alu,bus_acc,bus_imm,a_load,b_load,out_load,alu_sub,halted}
    localparam logic [10:0] NONE = 11'h000;
    localparam logic [10:0] RD   = 11'h400;
    localparam logic [10:0] RDY  = 11'h200;
    localparam logic [10:0] BIN  = 11'h100;
    localparam logic [10:0] BALU = 11'h080;
    localparam logic [10:0] BACC = 11'h040;
    localparam logic [10:0] BIMM = 11'h020;
    localparam logic [10:0] AL   = 11'h010;
    localparam logic [10:0] BL   = 11'h008;
    localparam logic [10:0] OL   = 11'h004;
    localparam logic [10:0] SUB  = 11'h002;
    localparam logic [10:0] HLT  = 11'h001;

    typedef struct packed {
        logic        clr;
        logic        run;
        logic        step;
        logic        in_valid;
        logic        acc_zero;
        logic [10:0] sig;
        logic [2:0]  pc;
        logic [3:0]  imm;
    } vec_t;

    vec_t vq[$];
    int   checks   = 0;
    int   failures = 0;

    task automatic add(input logic clr, input logic run, input logic step, input logic iv,
                       input logic az, input logic [10:0] sig, input logic [2:0] pc,
                       input logic [3:0] imm);
        vec_t v;
        v.clr = clr; v.run = run; v.step = step; v.in_valid = iv; v.acc_zero = az;
        v.sig = sig; v.pc = pc; v.imm = imm;
        vq.push_back(v);
    endtask

    function automatic logic [10:0] obs_sig();
        return {sif.mem_rd, sif.in_ready, sif.bus_in_en, sif.bus_alu_en, sif.bus_acc_en,
                sif.bus_imm_en, sif.a_load, sif.b_load, sif.out_load, sif.alu_sub, sif.halted};
    endfunction

    // Clear for one edge with all inputs idle; the next row samples the IDLE cycle.
    task automatic do_reset();
        @(negedge MainClock);
        MainClear    = 1'b1;
        sif.run      = 1'b0;
        sif.step     = 1'b0;
        sif.in_valid = 1'b0;
        sif.acc_zero = 1'b0;
    endtask

    // Apply each row's inputs mid-cycle, then compare outputs before the next rising edge.
    task automatic play(input string name);
        logic [10:0] act;
        for (int i = 0; i < vq.size(); i++) begin
            @(negedge MainClock);
            MainClear    = vq[i].clr;
            sif.run      = vq[i].run;
            sif.step     = vq[i].step;
            sif.in_valid = vq[i].in_valid;
            sif.acc_zero = vq[i].acc_zero;
            #1;
            act = obs_sig();
            checks++;
            if ({act, sif.pc, sif.mem_addr, sif.imm} !== {vq[i].sig, vq[i].pc, vq[i].pc, vq[i].imm}) begin
                failures++;
                $display("FAIL %s[%0d] sig/pc/addr/imm got %h/%0d/%0d/%h want %h/%0d/%0d/%h",
                         name, i, act, sif.pc, sif.mem_addr, sif.imm,
                         vq[i].sig, vq[i].pc, vq[i].pc, vq[i].imm);
            end
            checks++;
            if ($countones(act[8:5]) > 1) begin
                failures++;
                $display("FAIL %s[%0d] bus_onehot enables=%b want at most one set", name, i, act[8:5]);
            end
        end
        vq.delete();
    endtask

    initial begin
        MainClear    = 1'b1;
        sif.run      = 1'b0;
        sif.step     = 1'b0;
        sif.in_valid = 1'b0;
        sif.acc_zero = 1'b0;
        for (int i = 0; i < 8; i++) mem[i] = 8'h00;

        // LDA 3, LDB 2, ADD, OUT, HLT in free-run, then clear out of HALT
        mem[0] = 8'h63; mem[1] = 8'h52; mem[2] = 8'h10; mem[3] = 8'h30; mem[4] = 8'hF0;
        do_reset();
        add(0,1,0,0,0, NONE,      3'd0, 4'h0);
        add(0,1,0,0,0, RD,        3'd0, 4'h0);
        add(0,1,0,0,0, NONE,      3'd0, 4'h0);
        add(0,1,0,0,0, BIMM|AL,   3'd1, 4'h3);
        add(0,1,0,0,0, RD,        3'd1, 4'h3);
        add(0,1,0,0,0, NONE,      3'd1, 4'h3);
        add(0,1,0,0,0, BIMM|BL,   3'd2, 4'h2);
        add(0,1,0,0,0, RD,        3'd2, 4'h2);
        add(0,1,0,0,0, NONE,      3'd2, 4'h2);
        add(0,1,0,0,0, BALU|AL,   3'd3, 4'h0);
        add(0,1,0,0,0, RD,        3'd3, 4'h0);
        add(0,1,0,0,0, NONE,      3'd3, 4'h0);
        add(0,1,0,0,0, BACC|OL,   3'd4, 4'h0);
        add(0,1,0,0,0, RD,        3'd4, 4'h0);
        add(0,1,0,0,0, NONE,      3'd4, 4'h0);
        add(0,1,0,0,0, HLT,       3'd5, 4'h0);
        add(0,1,0,0,0, HLT,       3'd5, 4'h0);
        add(0,0,1,0,0, HLT,       3'd5, 4'h0);
        add(0,1,0,0,0, HLT,       3'd5, 4'h0);
        add(1,0,0,0,0, HLT,       3'd5, 4'h0);
        add(0,0,0,0,0, NONE,      3'd0, 4'h0);
        add(0,0,0,0,0, NONE,      3'd0, 4'h0);
        play("prog");

        // Single-step: NOP 0x9A, SUB, NOP; a step pulse during FETCH is dropped
        for (int i = 0; i < 8; i++) mem[i] = 8'h00;
        mem[0] = 8'h9A; mem[1] = 8'h21;
        do_reset();
        add(0,0,0,0,0, NONE,        3'd0, 4'h0);
        add(0,0,1,0,0, NONE,        3'd0, 4'h0);
        add(0,0,1,0,0, RD,          3'd0, 4'h0);
        add(0,0,0,0,0, NONE,        3'd0, 4'h0);
        add(0,0,0,0,0, NONE,        3'd1, 4'hA);
        add(0,0,0,0,0, NONE,        3'd1, 4'hA);
        add(0,0,0,0,0, NONE,        3'd1, 4'hA);
        add(0,0,1,0,0, NONE,        3'd1, 4'hA);
        add(0,0,0,0,0, RD,          3'd1, 4'hA);
        add(0,0,0,0,0, NONE,        3'd1, 4'hA);
        add(0,0,0,0,0, BALU|AL|SUB, 3'd2, 4'h1);
        add(0,0,0,0,0, NONE,        3'd2, 4'h1);
        add(0,0,1,0,0, NONE,        3'd2, 4'h1);
        add(0,0,0,0,0, RD,          3'd2, 4'h1);
        add(0,0,0,0,0, NONE,        3'd2, 4'h1);
        add(0,0,0,0,0, NONE,        3'd3, 4'h0);
        add(0,0,0,0,0, NONE,        3'd3, 4'h0);
        add(0,0,0,0,0, NONE,        3'd3, 4'h0);
        play("step");

        // IN with early in_valid ignored, 5 wait cycles, then accept and continue to HLT
        for (int i = 0; i < 8; i++) mem[i] = 8'h00;
        mem[0] = 8'h40; mem[1] = 8'hF0;
        do_reset();
        add(0,1,0,1,0, NONE,       3'd0, 4'h0);
        add(0,1,0,1,0, RD,         3'd0, 4'h0);
        add(0,1,0,1,0, NONE,       3'd0, 4'h0);
        add(0,1,0,1,0, NONE,       3'd1, 4'h0);
        for (int i = 0; i < 5; i++) add(0,1,0,0,0, RDY, 3'd1, 4'h0);
        add(0,1,0,1,0, RDY|BIN|AL, 3'd1, 4'h0);
        add(0,1,0,0,0, RD,         3'd1, 4'h0);
        add(0,1,0,0,0, NONE,       3'd1, 4'h0);
        add(0,1,0,0,0, HLT,        3'd2, 4'h0);
        add(0,1,0,0,0, HLT,        3'd2, 4'h0);
        play("in_wait");

        // Clear while waiting for input dominates a concurrent in_valid
        do_reset();
        add(0,1,0,0,0, NONE,       3'd0, 4'h0);
        add(0,1,0,0,0, RD,         3'd0, 4'h0);
        add(0,1,0,0,0, NONE,       3'd0, 4'h0);
        add(0,1,0,0,0, NONE,       3'd1, 4'h0);
        add(0,1,0,0,0, RDY,        3'd1, 4'h0);
        add(1,1,0,1,0, RDY|BIN|AL, 3'd1, 4'h0);
        add(0,0,0,0,0, NONE,       3'd0, 4'h0);
        add(0,0,0,0,0, NONE,       3'd0, 4'h0);
        play("clr_wait_in");

        // JMP 7 then pc wraps 7->0; run dropped during FETCH finishes the instruction
        for (int i = 0; i < 8; i++) mem[i] = 8'h00;
        mem[0] = 8'h77;
        do_reset();
        add(0,1,0,0,0, NONE, 3'd0, 4'h0);
        add(0,1,0,0,0, RD,   3'd0, 4'h0);
        add(0,1,0,0,0, NONE, 3'd0, 4'h0);
        add(0,1,0,0,0, NONE, 3'd1, 4'h7);
        add(0,0,0,0,0, RD,   3'd7, 4'h7);
        add(0,0,0,0,0, NONE, 3'd7, 4'h7);
        add(0,0,0,0,0, NONE, 3'd0, 4'h0);
        add(0,0,0,0,0, NONE, 3'd0, 4'h0);
        add(0,0,0,0,0, NONE, 3'd0, 4'h0);
        play("wrap");

        // JZ taken, then JMP 2 self-loop refetching address 2
        mem[0] = 8'h82; mem[2] = 8'h72;
        do_reset();
        add(0,0,1,0,0, NONE, 3'd0, 4'h0);
        add(0,0,0,0,0, RD,   3'd0, 4'h0);
        add(0,0,0,0,0, NONE, 3'd0, 4'h0);
        add(0,0,0,0,1, NONE, 3'd1, 4'h2);
        add(0,0,0,0,0, NONE, 3'd2, 4'h2);
        add(0,1,0,0,0, NONE, 3'd2, 4'h2);
        for (int k = 0; k < 2; k++) begin
            add(0,1,0,0,0, RD,   3'd2, 4'h2);
            add(0,1,0,0,0, NONE, 3'd2, 4'h2);
            add(0,1,0,0,0, NONE, 3'd3, 4'h2);
        end
        add(0,0,0,0,0, RD,   3'd2, 4'h2);
        add(0,0,0,0,0, NONE, 3'd2, 4'h2);
        add(0,0,0,0,0, NONE, 3'd3, 4'h2);
        add(0,0,0,0,0, NONE, 3'd2, 4'h2);
        play("jz_taken");

        // JZ not taken keeps the incremented pc
        do_reset();
        add(0,0,1,0,1, NONE, 3'd0, 4'h0);
        add(0,0,0,0,1, RD,   3'd0, 4'h0);
        add(0,0,0,0,1, NONE, 3'd0, 4'h0);
        add(0,0,0,0,0, NONE, 3'd1, 4'h2);
        add(0,0,0,0,0, NONE, 3'd1, 4'h2);
        play("jz_not_taken");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/instr_sequencer.md
Name: instr_sequencer

Overview:
- Control unit for the 4-bit accumulator microprocessor datapath: accumulator A, operand register B, output register, add/sub ALU and the shared 4-bit bus.
- Fetches 8-bit instructions from the 8x8 program memory and decodes them.
- Emits one-hot bus-driver enables and register load strobes, and handles run/step/halt and the IN handshake.
- Replaces the free-running 4-phase ring-counter timing with an explicit FSM.

Parameters:
- PC_W, 3, program counter / memory address width (8 words).
- DATA_W, 4, datapath and bus width.
- OPC_W, 4, opcode field width; instruction = {opcode[7:4], operand[3:0]}.

Ports:
- MainClock  in  1  sole clock; all state changes on rising edge.
- MainClear  in  1  synchronous active-high reset.
- run  in  1  level; 1 = free-run, 0 = single-step mode.
- step  in  1  1-cycle pulse; in IDLE, starts execution of one instruction.
- mem_addr  out  PC_W  program memory address.
- mem_rd  out  1  memory read strobe; data valid on mem_rdata the next cycle.
- mem_rdata  in  8  instruction word.
- in_valid  in  1  external nibble on in_data is valid.
- in_ready  out  1  sequencer waiting for input.
- bus_in_en  out  1  drive in_data onto bus.
- bus_alu_en  out  1  drive ALU result onto bus.
- bus_acc_en  out  1  drive A onto bus.
- bus_imm_en  out  1  drive operand field onto bus.
- imm  out  DATA_W  IR operand field.
- a_load  out  1  A <= bus.
- b_load  out  1  B <= bus.
- out_load  out  1  output register <= bus.
- alu_sub  out  1  ALU subtracts (B inverted, carry-in 1).
- acc_zero  in  1  A == 0.
- halted  out  1  HLT executed.
- pc  out  PC_W  current program counter.

Behaviour:
- Reset (MainClear=1 at edge):
  - state=IDLE, pc=0, ir=0x00.
  - All strobes, enables, in_ready, halted, mem_rd = 0.
  - Reset dominates every other input, including mid-WAIT_IN and HALT.
- States: IDLE, FETCH, LATCH, EXEC, WAIT_IN, HALT. Exactly one bus enable may be 1 in any cycle; all strobes are combinational from state+ir and last exactly one cycle.
- IDLE: moves to FETCH when run=1 or step=1.
- FETCH: mem_rd=1, mem_addr=pc. Next state LATCH.
- LATCH: ir <= mem_rdata; pc <= pc+1, wrapping 7 -> 0. Next state EXEC.
- EXEC decodes ir[7:4]:
  - 0 NOP: no strobes.
  - 1 ADD: bus_alu_en, a_load, alu_sub=0.
  - 2 SUB: bus_alu_en, a_load, alu_sub=1.
  - 3 OUT: bus_acc_en, out_load.
  - 4 IN: go to WAIT_IN; no strobe in EXEC.
  - 5 LDB: bus_imm_en, b_load.
  - 6 LDA: bus_imm_en, a_load.
  - 7 JMP: pc <= ir[PC_W-1:0].
  - 8 JZ: if acc_zero, pc <= ir[PC_W-1:0], else pc unchanged.
  - F HLT: go to HALT.
  - 9..E: treated as NOP.
- After EXEC (other than IN/HLT): FETCH if run=1, else IDLE. The same rule applies after WAIT_IN completes.
- Latency: 3 cycles per instruction (FETCH, LATCH, EXEC), plus wait cycles for IN.
- WAIT_IN:
  - in_ready=1.
  - On the cycle in_valid=1: bus_in_en=1, a_load=1, then leave per the run rule.
  - in_valid before WAIT_IN is ignored, with no buffering.
- HALT: halted=1; stays until MainClear; run and step are ignored.
- step:
  - Sampled only in IDLE.
  - While run=1, step is ignored.
  - A step pulse during an instruction is dropped.
- Dropping run mid-instruction completes the current instruction, then goes to IDLE.
- JMP/JZ target overrides the LATCH increment. JMP to the current address is a legal self-loop.

Decomposition:
- Package seq_pkg:
  - Opcode localparams OP_NOP..OP_HLT.
  - State enum encoding.
  - Field slice constants OPC_MSB=7, OPC_LSB=4.
- One natural sub-module: instr_decode, a combinational mapping from opcode + state + acc_zero + in_valid to enables/strobes/next-pc-select. The FSM, pc and ir stay in instr_sequencer.

Test Plan:
- Reset then run=1; memory [0]=0x63, [1]=0x52, [2]=0x10, [3]=0x30, [4]=0xF0 -> a_load with imm=3 at cycle 3; b_load with imm=2 at cycle 6; bus_alu_en+a_load alu_sub=0 at cycle 9; out_load at cycle 12; halted=1 from cycle 15; pc=5 at halt.
- run=0; three step pulses in IDLE over [0]=0x00,[1]=0x00 -> each step yields exactly one FETCH/LATCH/EXEC then IDLE; pc 0->1->2->3. A step during FETCH is dropped, pc unchanged.
- [0]=0x40 IN, hold in_valid=0 for 5 cycles then 1 -> in_ready=1 for 6 cycles; bus_in_en+a_load in exactly the in_valid cycle.
- Wrap/branch: [7]=0x00 -> pc wraps 7->0. [0]=0x82 with acc_zero=1 -> pc=2; with acc_zero=0 -> pc=1. [2]=0x72 -> repeated fetch of address 2.
- MainClear asserted during WAIT_IN and during HALT -> next cycle state IDLE, pc=0, all outputs 0, halted=0.
- Check every cycle that at most one bus enable is set, and that 0x9A decodes as a NOP.
